// File: rtl/ma_seq_ctrl.sv
// Frame sequencer for the MA_stage0 multiply-accumulator: feeds operand pairs,
// waits out the MAC pipeline, then rounds/saturates the frame sum to OW bits.
module ma_seq_ctrl #(
   parameter int DW      = 18,
   parameter int PW      = 96,
   parameter int LEN_W   = 10,
   parameter int MAC_LAT = 2,
   parameter int OW      = 32,
   parameter int SHIFT   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [PW-1:0]    cfg_bias,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DW-1:0]    s_a,
   input  logic [DW-1:0]    s_b,
   output logic             mac_ce,
   output logic             mac_reload,
   output logic [DW-1:0]    mac_a,
   output logic [DW-1:0]    mac_b,
   output logic [PW-1:0]    mac_acc_init,
   input  logic [PW-1:0]    mac_p,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OW-1:0]    m_data,
   output logic             m_sat
);

   // Both streams: a transfer happens on a rising edge where valid && ready are
   // both high; the producer keeps valid and its payload stable until then.

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

   localparam logic [PW:0]        ONE = {{PW{1'b0}}, 1'b1};
   localparam logic signed [PW:0] RND = $signed((ONE << SHIFT) >> 1);

   state_t              state;
   logic [LEN_W-1:0]    len;
   logic [LEN_W-1:0]    count;
   logic [LEN_W-1:0]    next_count;
   logic [LEN_W-1:0]    eff_len;
   logic [MAC_LAT-1:0]  drain_pipe;
   logic                fire;
   logic                last_fire;
   logic signed [PW:0]  r_ext;
   logic signed [PW:0]  t_full;
   logic [OW-1:0]       res_data;
   logic                res_sat;

   assign s_ready    = !rst && (state == IDLE || state == ACC);
   assign fire       = s_valid && s_ready;
   assign mac_ce     = !rst;
   assign mac_reload = fire && (state == IDLE);
   // Bubbles feed zero operands so the accumulator just adds zero.
   assign mac_a      = fire ? s_a : '0;
   assign mac_b      = fire ? s_b : '0;

   assign eff_len    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
   assign next_count = count + 1'b1;
   assign last_fire  = fire && (((state == IDLE) && (eff_len == LEN_W'(1))) ||
                                ((state == ACC) && (next_count == len)));

   // Round half up at PW+1 bits, then clip to the signed OW-bit range.
   always_comb begin
      r_ext    = $signed({mac_p[PW-1], mac_p});
      t_full   = (r_ext + RND) >>> SHIFT;
      res_data = t_full[OW-1:0];
      res_sat  = 1'b0;
      if (!((&t_full[PW:OW-1]) || (~|t_full[PW:OW-1]))) begin
         res_sat  = 1'b1;
         res_data = t_full[PW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         len          <= '0;
         count        <= '0;
         drain_pipe   <= '0;
         mac_acc_init <= '0;
         m_valid      <= 1'b0;
         m_data       <= '0;
         m_sat        <= 1'b0;
      end else begin
         // The last term's flag ages MAC_LAT cycles; its exit marks mac_p final.
         drain_pipe <= MAC_LAT'({drain_pipe, last_fire});
         case (state)
            IDLE: begin
               if (fire) begin
                  len          <= eff_len;
                  mac_acc_init <= cfg_bias;
                  count        <= LEN_W'(1);
                  state        <= (eff_len == LEN_W'(1)) ? DRAIN : ACC;
               end
            end
            ACC: begin
               if (fire) begin
                  count <= next_count;
                  if (next_count == len) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_pipe[MAC_LAT-1]) begin
                  m_data  <= res_data;
                  m_sat   <= res_sat;
                  m_valid <= 1'b1;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ma_seq_ctrl.sv
// Bench for ma_seq_ctrl: two instances (SHIFT=0 and SHIFT=16) share one stimulus
// stream, each wrapped by a 2-cycle MAC model, checked against an arithmetic model.
module tb_ma_seq_ctrl;

   logic               clk = 1'b0;
   logic               rst;
   logic [9:0]         cfg_len;
   logic [95:0]        cfg_bias;
   logic               s_valid;
   logic [17:0]        s_a;
   logic [17:0]        s_b;
   logic               m_ready;

   logic               s_ready_v[2];
   logic               mac_ce_v[2];
   logic               mac_reload_v[2];
   logic [17:0]        mac_a_v[2];
   logic [17:0]        mac_b_v[2];
   logic [95:0]        mac_acc_init_v[2];
   logic [95:0]        mac_p_v[2];
   logic               m_valid_v[2];
   logic [31:0]        m_data_v[2];
   logic               m_sat_v[2];

   int                 cyc = 0;
   int                 errors = 0;
   int                 checks = 0;
   logic signed [17:0] fa[16];
   logic signed [17:0] fb[16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int SH = (g == 0) ? 0 : 16;
      logic [17:0]        ma1, mb1;
      logic               r1;
      logic [95:0]        acc;
      logic signed [95:0] ea, eb, prod;

      ma_seq_ctrl #(.DW(18), .PW(96), .LEN_W(10), .MAC_LAT(2), .OW(32), .SHIFT(SH)) u_dut (
         .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
         .s_valid(s_valid), .s_ready(s_ready_v[g]), .s_a(s_a), .s_b(s_b),
         .mac_ce(mac_ce_v[g]), .mac_reload(mac_reload_v[g]),
         .mac_a(mac_a_v[g]), .mac_b(mac_b_v[g]), .mac_acc_init(mac_acc_init_v[g]),
         .mac_p(mac_p_v[g]), .m_valid(m_valid_v[g]), .m_ready(m_ready),
         .m_data(m_data_v[g]), .m_sat(m_sat_v[g]));

      // MAC model: operands registered, then accumulated (or reloaded) one cycle later.
      assign ea   = 96'($signed(ma1));
      assign eb   = 96'($signed(mb1));
      assign prod = ea * eb;
      always @(posedge clk) begin
         if (rst) begin
            ma1 <= '0; mb1 <= '0; r1 <= 1'b0; acc <= '0;
         end else if (mac_ce_v[g]) begin
            ma1 <= mac_a_v[g];
            mb1 <= mac_b_v[g];
            r1  <= mac_reload_v[g];
            acc <= r1 ? (mac_acc_init_v[g] + prod) : (acc + prod);
         end
      end
      assign mac_p_v[g] = acc;
   end

   function automatic void model(input logic signed [127:0] sum, input int sh,
                                 output logic [31:0] d, output logic s);
      logic signed [127:0] half, t;
      half = (sh == 0) ? 128'sd0 : (128'sd1 <<< (sh - 1));
      t = (sum + half) >>> sh;
      if (t > 128'sd2147483647) begin
         d = 32'h7FFF_FFFF; s = 1'b1;
      end else if (t < -128'sd2147483648) begin
         d = 32'h8000_0000; s = 1'b1;
      end else begin
         d = t[31:0]; s = 1'b0;
      end
   endfunction

   // Entered at posedge+1; returns at posedge+1 just after the pair was taken.
   task automatic push(input logic signed [17:0] a, input logic signed [17:0] b,
                       input int gap, output int t_fire);
      int n;
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_a = a; s_b = b;
      n = 0;
      t_fire = -100;
      forever begin
         @(negedge clk);
         if (s_ready_v[0] && s_ready_v[1]) break;
         n++;
         if (n > 40) begin
            checks++; errors++;
            $display("FAIL push_timeout: s_ready got %b/%b required 1", s_ready_v[0], s_ready_v[1]);
            @(posedge clk); #1; s_valid = 1'b0;
            return;
         end
      end
      t_fire = cyc;
      @(posedge clk); #1;
      s_valid = 1'b0; s_a = '0; s_b = '0;
   endtask

   // Waits for the result, checks it against the model, holds m_ready low for
   // 'hold' cycles, then completes the handshake. Returns at posedge+1.
   task automatic collect(input logic signed [127:0] sum, input int t_last, input int hold);
      logic [31:0] ed[2];
      logic        es[2];
      int          n;
      for (int g = 0; g < 2; g++) model(sum, (g == 0) ? 0 : 16, ed[g], es[g]);
      n = 0;
      forever begin
         @(negedge clk);
         if (m_valid_v[0]) break;
         n++;
         if (n > 60) begin
            checks++; errors++;
            $display("FAIL result_timeout: m_valid got 0 required 1");
            @(posedge clk); #1;
            return;
         end
      end
      checks++;
      if (cyc !== t_last + 3) begin
         errors++;
         $display("FAIL latency: m_valid rose in cycle %0d required %0d", cyc, t_last + 3);
      end
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (m_valid_v[g] !== 1'b1 || m_data_v[g] !== ed[g] || m_sat_v[g] !== es[g]) begin
            errors++;
            $display("FAIL result[%0d]: got v=%b d=%h sat=%b required v=1 d=%h sat=%b",
                     g, m_valid_v[g], m_data_v[g], m_sat_v[g], ed[g], es[g]);
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            checks++;
            if (m_valid_v[g] !== 1'b1 || m_data_v[g] !== ed[g] || m_sat_v[g] !== es[g] ||
                s_ready_v[g] !== 1'b0) begin
               errors++;
               $display("FAIL hold[%0d]: got v=%b d=%h sat=%b rdy=%b required v=1 d=%h sat=%b rdy=0",
                        g, m_valid_v[g], m_data_v[g], m_sat_v[g], s_ready_v[g], ed[g], es[g]);
            end
         end
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (m_valid_v[g] !== 1'b0 || s_ready_v[g] !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake[%0d]: got v=%b rdy=%b required v=0 rdy=1",
                     g, m_valid_v[g], s_ready_v[g]);
         end
      end
      @(posedge clk); #1;
   endtask

   // Sends fa/fb as one frame; cfg is scrambled after the first term.
   task automatic do_frame(input int len_cfg, input logic signed [127:0] bias,
                           input int gap_max, input int hold);
      logic signed [127:0] sum;
      int                  n, t;
      n = (len_cfg == 0) ? 1 : len_cfg;
      cfg_len  = 10'(len_cfg);
      cfg_bias = bias[95:0];
      sum = bias;
      t = 0;
      for (int i = 0; i < n; i++) begin
         push(fa[i], fb[i], $urandom_range(0, gap_max), t);
         sum = sum + fa[i] * fb[i];
         if (i == 0) begin
            cfg_len  = 10'($urandom_range(0, 1023));
            cfg_bias = {$urandom, $urandom, $urandom};
         end
      end
      collect(sum, t, hold);
   endtask

   task automatic load_basic();
      fa[0] = 1; fa[1] = 2; fa[2] = 3; fa[3] = 4;
      fb[0] = 5; fb[1] = 6; fb[2] = 7; fb[3] = 8;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
      cfg_len = '0; cfg_bias = '0;
      repeat (3) @(posedge clk);
      s_valid = 1'b1; s_a = 18'd7; s_b = 18'd9;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (s_ready_v[g] !== 1'b0 || m_valid_v[g] !== 1'b0 || m_data_v[g] !== 32'd0 ||
             m_sat_v[g] !== 1'b0 || mac_reload_v[g] !== 1'b0 || mac_a_v[g] !== 18'd0 ||
             mac_b_v[g] !== 18'd0 || mac_acc_init_v[g] !== 96'd0 || mac_ce_v[g] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got rdy=%b v=%b d=%h sat=%b rl=%b a=%h b=%h ce=%b required all 0",
                     g, s_ready_v[g], m_valid_v[g], m_data_v[g], m_sat_v[g], mac_reload_v[g],
                     mac_a_v[g], mac_b_v[g], mac_ce_v[g]);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (s_ready_v[g] !== 1'b1 || mac_ce_v[g] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset[%0d]: got rdy=%b ce=%b required 1/1", g, s_ready_v[g], mac_ce_v[g]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      load_basic();
      do_frame(4, 0, 0, 0);
      do_frame(4, 100, 0, 0);
   endtask

   task automatic test_rounding();
      fa[0] = 256; fb[0] = 256;
      do_frame(1, 128'sh7FFF, 0, 0);
      do_frame(1, 128'sh8000, 0, 0);
      do_frame(1, -128'sd98304, 0, 0);
      do_frame(1, -128'sd131072, 0, 0);
   endtask

   task automatic test_saturation();
      fa[0] = -131072; fb[0] = -131072; fa[1] = -131072; fb[1] = -131072;
      do_frame(2, 0, 0, 0);
      fb[0] = 131071; fb[1] = 131071;
      do_frame(2, 0, 0, 0);
   endtask

   task automatic test_bubbles_backpressure();
      fa[0] = -300; fa[1] = 1234; fa[2] = 77;
      fb[0] = 45;   fb[1] = -999; fb[2] = 131071;
      do_frame(3, 5, 0, 0);
      do_frame(3, 5, 3, 10);
   endtask

   task automatic test_reset_mid_frame();
      int t;
      load_basic();
      cfg_len = 10'd4; cfg_bias = 96'd1000;
      push(fa[0], fb[0], 0, t);
      push(fa[1], fb[1], 0, t);
      rst = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (s_ready_v[g] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready[%0d]: got %b required 0", g, s_ready_v[g]);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            checks++;
            if (m_valid_v[g] !== 1'b0) begin
               errors++;
               $display("FAIL rst_mid_valid[%0d]: got %b required 0", g, m_valid_v[g]);
            end
         end
      end
      @(posedge clk); #1;
      do_frame(4, 0, 0, 0);
   endtask

   task automatic test_len_zero();
      int t;
      cfg_len = 10'd0; cfg_bias = 96'd0;
      push(18'sd3, -18'sd5, 0, t);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (s_ready_v[g] !== 1'b0) begin
            errors++;
            $display("FAIL len0_ready[%0d]: got %b required 0", g, s_ready_v[g]);
         end
      end
      collect(-128'sd15, t, 0);
   endtask

   task automatic test_back_to_back();
      int  t, cnt;
      logic [31:0] d0;
      logic        s0;
      bit  seen;
      fa[0] = 1000; fb[0] = -2000; fa[1] = -7; fb[1] = 9;
      model(128'sd1000 * -128'sd2000 + (-128'sd63) + 128'sd42, 0, d0, s0);
      m_ready = 1'b1;
      cfg_len = 10'd2; cfg_bias = 96'd42;
      push(fa[0], fb[0], 0, t);
      push(fa[1], fb[1], 0, t);
      cnt = 0; seen = 0;
      forever begin
         @(negedge clk);
         if (s_ready_v[0] || cnt > 20) break;
         cnt++;
         if (m_valid_v[0]) begin
            seen = 1;
            checks++;
            if (m_data_v[0] !== d0 || m_sat_v[0] !== s0) begin
               errors++;
               $display("FAIL b2b_result: got d=%h sat=%b required d=%h sat=%b", m_data_v[0], m_sat_v[0], d0, s0);
            end
         end
      end
      checks++;
      if (cnt !== 3 || !seen) begin
         errors++;
         $display("FAIL b2b_gap: s_ready low %0d cycles seen=%0d required 3 cycles seen=1", cnt, seen);
      end
      @(posedge clk); #1;
      m_ready = 1'b0;
      load_basic();
      do_frame(4, 0, 0, 0);
   endtask

   task automatic test_random();
      logic signed [127:0] bias;
      int                  len;
      for (int f = 0; f < 12; f++) begin
         len = $urandom_range(0, 6);
         for (int i = 0; i < 6; i++) begin
            fa[i] = 18'($urandom_range(0, 262143));
            fb[i] = 18'($urandom_range(0, 262143));
         end
         if ($urandom_range(0, 1) == 0)
            bias = 128'($signed(21'($urandom_range(0, 2097151))));
         else
            bias = 128'($signed({$urandom, $urandom}));
         do_frame(len, bias, 2, $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_bubbles_backpressure();
      test_reset_mid_frame();
      test_len_zero();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
